// File: rtl/rom_arbiter.sv
// Fetch/debug arbiter for the instruction ROM read port.
// Fetch has priority; a starvation counter bounds the debug wait.
module rom_arbiter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        f_req,
    input  logic [14:0] f_addr,
    output logic        f_gnt,
    output logic        f_valid,
    output logic [15:0] f_data,
    input  logic        d_req,
    input  logic [14:0] d_addr,
    output logic        d_gnt,
    output logic        d_valid,
    output logic [15:0] d_data,
    output logic [14:0] rom_address,
    input  logic [15:0] rom_out
);

    localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

    logic [7:0]  wait_q, wait_d;
    logic [14:0] last_addr_q, last_addr_d;
    logic [1:0]  owner_q, owner_d;
    logic        starve;

    always_comb begin
        starve      = (wait_q == WAIT_MAX) && d_req;
        d_gnt       = reset_n && d_req && (starve || !f_req);
        f_gnt       = reset_n && f_req && !starve;
        rom_address = last_addr_q;
        if (f_gnt) begin
            rom_address = f_addr;
        end else if (d_gnt) begin
            rom_address = d_addr;
        end
        last_addr_d = rom_address;
        owner_d     = {d_gnt, f_gnt};
        // Counter only runs while debug is actively being denied
        wait_d      = 8'd0;
        if (d_req && !d_gnt) begin
            wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_q      <= 8'd0;
            last_addr_q <= 15'd0;
            owner_q     <= 2'b00;
        end else begin
            wait_q      <= wait_d;
            last_addr_q <= last_addr_d;
            owner_q     <= owner_d;
        end
    end

    assign f_valid = owner_q[0];
    assign d_valid = owner_q[1];
    assign f_data  = rom_out;
    assign d_data  = rom_out;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: vector table, hand sequences and
// randomized traffic against a behavioural model.
module tb_rom_arbiter;

    localparam int MW = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        f_req = 1'b0;
    logic        d_req = 1'b0;
    logic [14:0] f_addr = 15'd0;
    logic [14:0] d_addr = 15'd0;
    logic        f_gnt, f_valid, d_gnt, d_valid;
    logic [15:0] f_data, d_data;
    logic [14:0] rom_address;
    logic [15:0] rom_out;
    logic [15:0] mem [32768];

    int n_pass = 0;
    int n_tot  = 0;

    rom_arbiter #(.MAX_WAIT(MW)) dut (
        .clock(clock), .reset_n(reset_n),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
        .f_valid(f_valid), .f_data(f_data),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt),
        .d_valid(d_valid), .d_data(d_data),
        .rom_address(rom_address), .rom_out(rom_out)
    );

    always #5 clock = ~clock;

    always @(posedge clock) rom_out <= mem[rom_address];

    typedef struct {
        logic        fr;
        logic [14:0] fa;
        logic        dr;
        logic [14:0] da;
        logic        fg;
        logic        dg;
        logic        fv;
        logic        dv;
        logic [14:0] ra;
        logic [14:0] dat_a;
    } vec_t;

    vec_t tbl [23];

    // behavioural model state
    int          m_wait;
    logic [14:0] m_last;
    logic        m_fv, m_dv;
    logic [15:0] m_data;

    task automatic chk(string nm, int act, int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic vec_t mk(logic fr, int fa, logic dr, int da,
                                logic fg, logic dg, logic fv, logic dv,
                                int ra, int dat_a);
        vec_t v;
        v.fr = fr; v.fa = 15'(fa); v.dr = dr; v.da = 15'(da);
        v.fg = fg; v.dg = dg; v.fv = fv; v.dv = dv;
        v.ra = 15'(ra); v.dat_a = 15'(dat_a);
        return v;
    endfunction

    task automatic drive(logic fr, logic [14:0] fa, logic dr, logic [14:0] da);
        @(posedge clock);
        #1;
        f_req = fr; f_addr = fa; d_req = dr; d_addr = da;
        #1;
    endtask

    task automatic do_reset();
        f_req = 0; d_req = 0; f_addr = 0; d_addr = 0;
        reset_n = 0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1;
        m_wait = 0; m_last = 0; m_fv = 0; m_dv = 0; m_data = 0;
    endtask

    task automatic model_cycle(logic fr, logic [14:0] fa, logic dr, logic [14:0] da);
        logic eg_f, eg_d;
        logic [14:0] ea;
        drive(fr, fa, dr, da);
        eg_d = dr && (m_wait == MW || !fr);
        eg_f = fr && !eg_d;
        ea = eg_f ? fa : (eg_d ? da : m_last);
        chk("rnd_f_gnt", int'(f_gnt), int'(eg_f));
        chk("rnd_d_gnt", int'(d_gnt), int'(eg_d));
        chk("rnd_rom_address", int'(rom_address), int'(ea));
        chk("rnd_f_valid", int'(f_valid), int'(m_fv));
        chk("rnd_d_valid", int'(d_valid), int'(m_dv));
        if (m_fv) chk("rnd_f_data", int'(f_data), int'(m_data));
        if (m_dv) chk("rnd_d_data", int'(d_data), int'(m_data));
        m_fv = eg_f;
        m_dv = eg_d;
        m_data = mem[ea];
        m_last = ea;
        if (dr && !eg_d) m_wait = (m_wait + 1 > MW) ? MW : m_wait + 1;
        else m_wait = 0;
    endtask

    initial begin
        int denied;
        bit got;
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        mem[1] = 16'hEFD0;

        // fr fa dr da | fg dg fv dv ra dat_a
        tbl[0]  = mk(1, 0, 1, 5,  1, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 1, 5,  1, 0, 1, 0, 1, 0);
        tbl[2]  = mk(1, 2, 1, 5,  1, 0, 1, 0, 2, 1);
        tbl[3]  = mk(1, 3, 1, 5,  1, 0, 1, 0, 3, 2);
        tbl[4]  = mk(1, 4, 1, 5,  0, 1, 1, 0, 5, 3);
        tbl[5]  = mk(1, 4, 0, 5,  1, 0, 0, 1, 4, 5);
        tbl[6]  = mk(1, 5, 0, 0,  1, 0, 1, 0, 5, 4);
        tbl[7]  = mk(0, 0, 1, 7,  0, 1, 1, 0, 7, 5);
        tbl[8]  = mk(0, 0, 0, 0,  0, 0, 0, 1, 7, 7);
        tbl[9]  = mk(1, 'h1234, 0, 0, 1, 0, 0, 0, 'h1234, 0);
        tbl[10] = mk(0, 0, 0, 0,  0, 0, 1, 0, 'h1234, 'h1234);
        tbl[11] = mk(0, 0, 0, 0,  0, 0, 0, 0, 'h1234, 0);
        tbl[12] = mk(0, 0, 0, 0,  0, 0, 0, 0, 'h1234, 0);
        tbl[13] = mk(0, 0, 0, 0,  0, 0, 0, 0, 'h1234, 0);
        tbl[14] = mk(0, 0, 0, 0,  0, 0, 0, 0, 'h1234, 0);
        tbl[15] = mk(1, 'h7FFF, 1, 1, 1, 0, 0, 0, 'h7FFF, 0);
        tbl[16] = mk(1, 0, 0, 0,  1, 0, 1, 0, 0, 'h7FFF);
        tbl[17] = mk(1, 1, 1, 9,  1, 0, 1, 0, 1, 0);
        tbl[18] = mk(1, 2, 1, 9,  1, 0, 1, 0, 2, 1);
        tbl[19] = mk(1, 3, 1, 9,  1, 0, 1, 0, 3, 2);
        tbl[20] = mk(1, 4, 1, 9,  1, 0, 1, 0, 4, 3);
        tbl[21] = mk(1, 5, 1, 9,  0, 1, 1, 0, 9, 4);
        tbl[22] = mk(0, 0, 0, 0,  0, 0, 0, 1, 9, 9);

        // reset held with a pending fetch
        reset_n = 0; f_req = 1; f_addr = 15'h0ABC;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #2;
            chk("rst_f_gnt", int'(f_gnt), 0);
            chk("rst_f_valid", int'(f_valid), 0);
            chk("rst_rom_address", int'(rom_address), 0);
        end
        @(posedge clock); #1 reset_n = 1; #1;
        chk("rel_f_gnt", int'(f_gnt), 1);
        chk("rel_rom_address", int'(rom_address), 'h0ABC);
        @(posedge clock); #2;
        chk("rel_f_valid", int'(f_valid), 1);
        chk("rel_f_data", int'(f_data), int'(mem[15'h0ABC]));

        // reset pulsed during a granted fetch
        drive(1, 15'h0100, 0, 0);
        chk("mid_f_gnt", int'(f_gnt), 1);
        #2 reset_n = 0; f_req = 0; #1;
        chk("mid_gnt_forced", int'(f_gnt), 0);
        @(posedge clock); #1;
        chk("mid_f_valid_low", int'(f_valid), 0);
        reset_n = 1; #1;
        chk("mid_f_valid_rel", int'(f_valid), 0);
        @(posedge clock); #2;
        chk("mid_f_valid_after", int'(f_valid), 0);

        // starvation count must restart after reset
        drive(1, 0, 1, 3);
        drive(1, 1, 1, 3);
        #1 reset_n = 0; f_req = 0; d_req = 0;
        @(posedge clock); #1 reset_n = 1;
        denied = 0; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            drive(1, 15'(i), 1, 3);
            if (d_gnt) got = 1;
            else denied++;
        end
        chk("starve_after_reset_granted", int'(got), 1);
        chk("starve_after_reset_wait", denied, MW);

        // vector table
        do_reset();
        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].fr, tbl[i].fa, tbl[i].dr, tbl[i].da);
            chk($sformatf("tbl%0d_f_gnt", i), int'(f_gnt), int'(tbl[i].fg));
            chk($sformatf("tbl%0d_d_gnt", i), int'(d_gnt), int'(tbl[i].dg));
            chk($sformatf("tbl%0d_f_valid", i), int'(f_valid), int'(tbl[i].fv));
            chk($sformatf("tbl%0d_d_valid", i), int'(d_valid), int'(tbl[i].dv));
            chk($sformatf("tbl%0d_rom_address", i), int'(rom_address), int'(tbl[i].ra));
            if (tbl[i].fv)
                chk($sformatf("tbl%0d_f_data", i), int'(f_data), int'(mem[tbl[i].dat_a]));
            if (tbl[i].dv)
                chk($sformatf("tbl%0d_d_data", i), int'(d_data), int'(mem[tbl[i].dat_a]));
            if (i == 2) chk("tbl_efd0", int'(f_data), 'hEFD0);
        end

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            model_cycle(($urandom % 4) != 0, 15'($urandom),
                        ($urandom % 3) == 0, 15'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Two-requester arbiter that shares the single synchronous-read port of the 32K×16 instruction ROM between the CPU instruction-fetch path and a debug/dump port. Fetch has fixed priority. A starvation counter guarantees the debug port a slot after a bounded wait. The arbiter steers the ROM address, tracks which requester owns the in-flight read, and returns the read data with a per-requester valid strobe one cycle after grant.

## Interface
- MAX_WAIT, default 4: number of consecutive denied debug-request cycles after which debug wins over fetch; legal range 1..255.
- clock  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- f_req  in  1  fetch request, sampled every cycle.
- f_addr  in  15  fetch word address.
- f_gnt  out  1  fetch granted this cycle (combinational).
- f_valid  out  1  f_data holds the word for the fetch granted last cycle.
- f_data  out  16  read data to fetch path.
- d_req  in  1  debug request.
- d_addr  in  15  debug word address.
- d_gnt  out  1  debug granted this cycle (combinational).
- d_valid  out  1  d_data holds the word for the debug read granted last cycle.
- d_data  out  16  read data to debug port.
- rom_address  out  15  address to ROM; the ROM registers it at the rising edge.
- rom_out  in  16  ROM registered read data.

## Operation
- Grant decision, combinational, each cycle:
  - If reset_n is low, no grant is issued.
  - If wait_cnt == MAX_WAIT and d_req is high, debug is granted.
  - Otherwise, if f_req is high, fetch is granted.
  - Otherwise, if d_req is high, debug is granted.
  - Otherwise, neither is granted.
  - f_gnt and d_gnt are never high together.
- rom_address:
  - Equals f_addr when f_gnt is high.
  - Equals d_addr when d_gnt is high.
  - With no grant, it equals last_addr, the register holding the most recently granted address. This keeps rom_out stable while idle.
- Owner register owner[1:0] = {d_gnt, f_gnt}, registered each cycle.
  - f_valid = owner[0]; d_valid = owner[1].
- f_data and d_data are both driven directly from rom_out. Consumers qualify them with their own valid.
- Starvation counter wait_cnt, 8 bits:
  - Increments when d_req=1 and d_gnt=0.
  - Clears to 0 when d_gnt=1 or d_req=0.
  - Saturates at MAX_WAIT.
- Requests are level-based. A requester holding req high is re-arbitrated every cycle, so back-to-back grants to the same requester are allowed and give one read per cycle.
- Address inputs are sampled only in the grant cycle. Changing an address while denied is legal.

## Timing
- Reset values:
  - f_valid, d_valid, owner = 0.
  - wait_cnt = 0.
  - last_addr = 0, so rom_address = 0 while no request is present.
  - f_gnt and d_gnt are forced to 0 while reset_n is low.
- Latency: grant in cycle N, data and valid in cycle N+1. Pipelined throughput is one read per cycle.
- Worst-case debug wait with continuous f_req: MAX_WAIT denied cycles, then a grant on the next cycle. Fetch is stalled for exactly that one cycle.
- Simultaneous f_req and d_req with wait_cnt < MAX_WAIT: fetch wins and wait_cnt increments.
- d_req dropped while waiting: wait_cnt clears. A re-asserted request starts counting from 0.
- Reset asserted mid-read:
  - The in-flight valid is discarded; owner clears asynchronously and no valid is emitted after reset release.
  - The first grant is possible in the first cycle with reset_n high.
- Addresses wrap naturally at 15 bits. No range checking is performed; all 32768 words are addressable.

## Test plan
- Reset then idle: hold reset_n=0 for 3 cycles with f_req=1 -> f_gnt=0, f_valid=0, rom_address=0. Release reset -> f_gnt=1 in the same cycle and f_valid=1 next cycle with f_data=mem[f_addr].
- Fetch streaming: f_req=1 with f_addr 0,1,2,3 on consecutive cycles and ROM preloaded mem[1]=16'hEFD0 -> f_valid high for 4 consecutive cycles, one cycle after each grant, with f_data in order and mem[1] returning 16'hEFD0.
- Starvation bound: MAX_WAIT=4, f_req=1 continuous, d_req=1 with d_addr=5 -> d_gnt low for 4 cycles, d_gnt=1 on cycle 5 with f_gnt=0, d_valid=1 on cycle 6 with d_data=mem[5]. Fetch resumes on cycle 6.
- Debug-only traffic: f_req=0, d_req=1 with d_addr=7 -> d_gnt=1 immediately, d_valid next cycle, wait_cnt stays 0.
- Idle hold: grant address 0x1234, then drop all requests for 5 cycles -> rom_address holds 0x1234 and no valid asserts.
- Mid-read reset: grant fetch at cycle N and pulse reset_n low during cycle N -> no f_valid at N+1, wait_cnt=0.
